// File: rtl/freq_spi_readout.sv
// freq_spi_readout: snapshots a bus of frequency counts and exposes them,
// plus a few identification/status bytes, through a mode-0 SPI slave
// running entirely in the sys_clk domain.
module freq_spi_readout #(
    parameter int CH_NUM = 2,
    parameter int CNT_W  = 28
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [CH_NUM*CNT_W-1:0] freq_bus,
    input  logic                    calc_flag,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    snap_valid,
    output logic                    busy
);

    localparam logic [7:0] ID_BYTE = 8'h46;

    typedef enum logic {SLOT_ADDR, SLOT_DATA} slot_t;

    logic                    sclk_meta, sclk_s, sclk_prev;
    logic                    mosi_meta, mosi_s;
    logic                    cs_meta, cs_s;
    logic [1:0]              sync_fill;
    logic                    armed;
    logic                    calc_prev;
    logic                    pending;
    logic [7:0]              snap_seq;
    logic [CH_NUM*CNT_W-1:0] snap_bus;
    logic [7:0]              addr;
    logic [2:0]              bit_cnt;
    logic [6:0]              rx_sr;
    logic [7:0]              tx_sr;
    logic                    load_pending;
    slot_t                   slot;
    logic [7:0]              rd_byte;
    logic [31:0]             word;

    logic cs_act, cs_fall, sclk_rise, sclk_fall, calc_rise;

    // CS only counts as active once it has been seen high after reset,
    // so a transaction already running at reset release is ignored.
    assign cs_act    = armed & ~cs_s;
    assign cs_fall   = cs_act & ~busy;
    assign sclk_rise = cs_act & sclk_s & ~sclk_prev;
    assign sclk_fall = cs_act & ~sclk_s & sclk_prev;
    assign calc_rise = calc_flag & ~calc_prev;
    assign spi_miso  = tx_sr[7];

    // Two-stage synchronisers plus edge-history registers; CS stages preset
    // high so reset looks like "not selected".
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_meta <= 1'b0;
            sclk_s    <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            sync_fill <= 2'd0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            calc_prev <= 1'b1;
        end else begin
            sclk_meta <= spi_sclk;
            sclk_s    <= sclk_meta;
            sclk_prev <= sclk_s;
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
            cs_meta   <= spi_cs_n;
            cs_s      <= cs_meta;
            if (!sync_fill[1]) begin
                sync_fill <= sync_fill + 2'd1;
            end
            armed     <= armed | (cs_s & sync_fill[1]);
            busy      <= cs_act;
            calc_prev <= calc_flag;
        end
    end

    // Snapshot capture: requests are held pending and applied only while no
    // transaction is in progress, so a master never sees data change mid-read.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending    <= 1'b0;
            snap_seq   <= 8'h00;
            snap_bus   <= '0;
            snap_valid <= 1'b0;
        end else if (pending && !cs_act) begin
            snap_bus   <= freq_bus;
            snap_seq   <= snap_seq + 8'd1;
            snap_valid <= 1'b1;
            pending    <= calc_rise;
        end else if (calc_rise) begin
            pending <= 1'b1;
        end
    end

    // Register map decode for the byte at the current address.
    always_comb begin
        rd_byte = 8'h00;
        word    = 32'h0;
        case (addr)
            8'h00:   rd_byte = ID_BYTE;
            8'h01:   rd_byte = 8'(CH_NUM);
            8'h02:   rd_byte = 8'(CNT_W);
            8'h03:   rd_byte = snap_seq;
            8'h04:   rd_byte = {7'b0, snap_valid};
            default: begin
                for (int k = 0; k < CH_NUM; k++) begin
                    if (addr[7:2] == 6'(4 + k)) begin
                        word[CNT_W-1:0] = snap_bus[k*CNT_W +: CNT_W];
                        case (addr[1:0])
                            2'd0:    rd_byte = word[7:0];
                            2'd1:    rd_byte = word[15:8];
                            2'd2:    rd_byte = word[23:16];
                            default: rd_byte = word[31:24];
                        endcase
                    end
                end
            end
        endcase
    end

    // SPI slave: first byte sets the address, every completed byte queues a
    // load of the next register byte onto the following SCLK fall.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr         <= 8'h00;
            bit_cnt      <= 3'd0;
            rx_sr        <= 7'h00;
            tx_sr        <= 8'h00;
            load_pending <= 1'b0;
            slot         <= SLOT_ADDR;
        end else if (!cs_act) begin
            bit_cnt      <= 3'd0;
            rx_sr        <= 7'h00;
            tx_sr        <= 8'h00;
            load_pending <= 1'b0;
            slot         <= SLOT_ADDR;
        end else if (cs_fall) begin
            bit_cnt      <= 3'd0;
            rx_sr        <= 7'h00;
            tx_sr        <= snap_seq;
            load_pending <= 1'b0;
            slot         <= SLOT_ADDR;
        end else if (sclk_rise) begin
            rx_sr   <= {rx_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                load_pending <= 1'b1;
                if (slot == SLOT_ADDR) begin
                    addr <= {rx_sr, mosi_s};
                    slot <= SLOT_DATA;
                end
            end
        end else if (sclk_fall) begin
            if (load_pending) begin
                tx_sr        <= rd_byte;
                addr         <= addr + 8'd1;
                load_pending <= 1'b0;
            end else begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_freq_spi_readout.sv
// tb_freq_spi_readout: directed scenarios for freq_spi_readout acting as
// an SPI master with SCLK at one tenth of sys_clk.
module tb_freq_spi_readout;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [55:0] freq_bus;
    logic        calc_flag;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        snap_valid;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  rd_data [8];
    logic [7:0]  status_byte;

    freq_spi_readout #(.CH_NUM(2), .CNT_W(28)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .freq_bus   (freq_bus),
        .calc_flag  (calc_flag),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .snap_valid (snap_valid),
        .busy       (busy)
    );

    // 100 MHz system clock
    always #5 sys_clk = ~sys_clk;

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #50;
    endtask

    task automatic cs_high();
        #50;
        spi_cs_n = 1'b1;
        #100;
    endtask

    // Full mode-0 byte: MISO sampled just before each rising SCLK edge.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #50;
            rx[i]    = spi_miso;
            spi_sclk = 1'b1;
            #50;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_read(input logic [7:0] a, input int n);
        logic [7:0] b;
        cs_low();
        spi_byte(a, b);
        status_byte = b;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, b);
            rd_data[i] = b;
        end
        cs_high();
    endtask

    task automatic pulse_calc();
        @(negedge sys_clk);
        calc_flag = 1'b1;
        @(negedge sys_clk);
        calc_flag = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        n_checks++;
        if (spi_miso !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (snap_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", snap_valid);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] exp0 [4] = '{8'hF1, 8'hDE, 8'hBC, 8'h0A};
        logic [7:0] exp1 [4] = '{8'h67, 8'h45, 8'h23, 8'h01};
        freq_bus = {28'h1234567, 28'hABCDEF1};
        pulse_calc();
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (snap_valid !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL snap_valid_set: got %b expected 1", snap_valid);
        end
        spi_read(8'h10, 4);
        n_checks++;
        if (status_byte !== 8'h01) begin
            n_errors++;
            $display("[TB] FAIL snap_status: got %02h expected 01", status_byte);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== exp0[i]) begin
                n_errors++;
                $display("[TB] FAIL ch0_byte%0d: got %02h expected %02h", i, rd_data[i], exp0[i]);
            end
        end
        spi_read(8'h14, 4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== exp1[i]) begin
                n_errors++;
                $display("[TB] FAIL ch1_byte%0d: got %02h expected %02h", i, rd_data[i], exp1[i]);
            end
        end
    endtask

    task automatic test_regmap();
        logic [7:0] exp [5] = '{8'h46, 8'h02, 8'h1C, 8'h01, 8'h01};
        spi_read(8'h00, 5);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rd_data[i] !== exp[i]) begin
                n_errors++;
                $display("[TB] FAIL regmap_%02h: got %02h expected %02h", i, rd_data[i], exp[i]);
            end
        end
        spi_read(8'h18, 1);
        n_checks++;
        if (rd_data[0] !== 8'h00) begin
            n_errors++;
            $display("[TB] FAIL regmap_unmapped: got %02h expected 00", rd_data[0]);
        end
    endtask

    task automatic test_busy();
        cs_low();
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL busy_active: got %b expected 1", busy);
        end
        cs_high();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL busy_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_coalesce();
        logic [7:0] b;
        logic [7:0] exp_old [4] = '{8'hF1, 8'hDE, 8'hBC, 8'h0A};
        logic [7:0] exp_new [4] = '{8'h34, 8'h12, 8'h00, 8'h00};
        cs_low();
        spi_byte(8'h10, b);
        spi_byte(8'h00, b);
        rd_data[0] = b;
        freq_bus = {28'h1234567, 28'h0001234};
        pulse_calc();
        pulse_calc();
        for (int i = 1; i < 4; i++) begin
            spi_byte(8'h00, b);
            rd_data[i] = b;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== exp_old[i]) begin
                n_errors++;
                $display("[TB] FAIL hold_byte%0d: got %02h expected %02h", i, rd_data[i], exp_old[i]);
            end
        end
        cs_high();
        spi_read(8'h10, 4);
        n_checks++;
        if (status_byte !== 8'h02) begin
            n_errors++;
            $display("[TB] FAIL coalesce_seq: got %02h expected 02", status_byte);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_data[i] !== exp_new[i]) begin
                n_errors++;
                $display("[TB] FAIL new_byte%0d: got %02h expected %02h", i, rd_data[i], exp_new[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [3] = '{8'h00, 8'h00, 8'h46};
        spi_read(8'hFE, 3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_data[i] !== exp[i]) begin
                n_errors++;
                $display("[TB] FAIL addr_wrap%0d: got %02h expected %02h", i, rd_data[i], exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] abort_addr = 8'h10;
        cs_low();
        for (int i = 7; i >= 4; i--) begin
            spi_mosi = abort_addr[i];
            #50;
            spi_sclk = 1'b1;
            #50;
            spi_sclk = 1'b0;
        end
        spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        n_checks++;
        if (spi_miso !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL abort_miso: got %b expected 0", spi_miso);
        end
        #100;
        spi_read(8'h01, 1);
        n_checks++;
        if (rd_data[0] !== 8'h02) begin
            n_errors++;
            $display("[TB] FAIL abort_next: got %02h expected 02", rd_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        cs_low();
        spi_byte(8'h00, b);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        calc_flag = 1'b1;
        #1;
        n_checks++;
        if (spi_miso !== 1'b0 || busy !== 1'b0 || snap_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL midreset_outputs: got miso=%b busy=%b valid=%b expected 0 0 0",
                     spi_miso, busy, snap_valid);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        n_checks++;
        if (snap_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL calc_at_release: got %b expected 0", snap_valid);
        end
        calc_flag = 1'b0;
        spi_byte(8'h03, b);
        spi_byte(8'h00, b);
        n_checks++;
        if (b !== 8'h00 || busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL ignored_xfer: got miso_byte=%02h busy=%b expected 00 0", b, busy);
        end
        cs_high();
        spi_read(8'h00, 1);
        n_checks++;
        if (status_byte !== 8'h00 || rd_data[0] !== 8'h46) begin
            n_errors++;
            $display("[TB] FAIL after_toggle: got seq=%02h id=%02h expected 00 46",
                     status_byte, rd_data[0]);
        end
    endtask

    task automatic test_seq_wrap();
        for (int i = 0; i < 255; i++) begin
            pulse_calc();
        end
        spi_read(8'h03, 1);
        n_checks++;
        if (rd_data[0] !== 8'hFF) begin
            n_errors++;
            $display("[TB] FAIL seq_ff: got %02h expected FF", rd_data[0]);
        end
        pulse_calc();
        spi_read(8'h03, 2);
        n_checks++;
        if (rd_data[0] !== 8'h00 || rd_data[1] !== 8'h01) begin
            n_errors++;
            $display("[TB] FAIL seq_wrap: got seq=%02h valid=%02h expected 00 01",
                     rd_data[0], rd_data[1]);
        end
    endtask

    // Scenario sequence
    initial begin
        sys_rst_n = 1'b0;
        freq_bus  = '0;
        calc_flag = 1'b0;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        repeat (3) @(negedge sys_clk);
        test_reset();
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        test_snapshot();
        test_regmap();
        test_busy();
        test_coalesce();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_seq_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_spi_readout.md
FREQ_SPI_READOUT -- requirements
Module: freq_spi_readout

Interface
REQ-001 Parameter CH_NUM, default 2: number of frequency channels, 1..8.
REQ-002 Parameter CNT_W, default 28: width of each channel count, 1..32.
REQ-003 sys_clk  input  1  system clock; all logic runs on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 freq_bus  input  CH_NUM*CNT_W  channel counts; channel k occupies bits [k*CNT_W +: CNT_W]; synchronous to sys_clk.
REQ-006 calc_flag  input  1  measurement-done strobe; a rising edge requests a snapshot; synchronous to sys_clk.
REQ-007 spi_sclk  input  1  SPI clock from master, asynchronous.
REQ-008 spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-009 spi_mosi  input  1  SPI data from master, asynchronous.
REQ-010 spi_miso  output  1  SPI data to master; driven 0 while CS is inactive; never tri-stated.
REQ-011 snap_valid  output  1  high once at least one snapshot has been applied since reset.
REQ-012 busy  output  1  equals synchronised CS active (spi_cs_n low).

Function
REQ-013 spi_sclk, spi_cs_n and spi_mosi shall each pass through a 2-FF synchroniser; SCLK edges and CS edges are detected in sys_clk; the supported ratio is sys_clk >= 8x SCLK.
REQ-014 SPI operates in mode 0, MSB first: MOSI is sampled on the SCLK rising edge; MISO changes only on the SCLK falling edge or the CS falling edge.
REQ-015 A calc_flag rising edge shall set the pending flag; a snapshot is applied on the first cycle in which pending=1 and synchronised CS is inactive, then pending clears.
REQ-016 Applying a snapshot copies all channels of freq_bus, as present in that cycle, into the snapshot registers; snap_seq (8-bit) increments and wraps 0xFF->0x00; snap_valid sets.
REQ-017 Further calc_flag edges while pending is set are coalesced into one snapshot; the snapshot is never altered during a transaction.
REQ-018 Transaction: the first byte received after CS falls is the start address; each later byte slot returns the byte at the current address; the address then increments, wrapping 0xFF->0x00. MOSI bits after the address byte are ignored.
REQ-019 On CS fall, the TX shift register loads snap_seq and spi_miso presents bit 7 within 3 sys_clk cycles.
REQ-020 The bit counter increments on each SCLK rise. When the 8th rise completes a byte (RX byte is the address in the first slot), TX loads the byte at the address on the next SCLK fall. All other SCLK falls shift TX left by 1.
REQ-021 Register map (read-only):
- 0x00 = 0x46 (ID)
- 0x01 = CH_NUM
- 0x02 = CNT_W
- 0x03 = snap_seq
- 0x04 = {7'b0, snap_valid}
- 0x10 + 4*k + b = byte b (b=0 is LSB) of channel k, zero-extended to 32 bits, for k < CH_NUM
- all other addresses read 0x00.
REQ-022 CS rising mid-byte shall abort: the bit counter clears, the partial byte is discarded, and spi_miso returns to 0 within 3 sys_clk cycles.
REQ-023 SCLK edges while synchronised CS is inactive shall be ignored.

Reset
REQ-024 On sys_rst_n low, the following shall clear to 0 immediately: snapshot registers, snap_seq, pending, snap_valid, address, bit counter, TX/RX shift registers, spi_miso and busy. The synchroniser stages for CS shall preset to 1; all other synchroniser stages shall clear.
REQ-025 After reset release, a transaction already in progress (CS low) shall be ignored until CS has been seen high; calc_flag high at release shall not count as an edge.

Verification
REQ-026 CH_NUM=2, CNT_W=28, freq_bus ch0=0x0ABCDEF1, calc_flag pulse with CS high; read address 0x10 for 4 bytes -> F1 DE BC 0A; status byte during the address slot = 0x01.
REQ-027 Read at 0x00 for 5 bytes after one snapshot -> 46 02 1C 01 01.
REQ-028 calc_flag edge during an active transaction -> data bytes unchanged until CS rises, then snapshot applies within 3 cycles of synchronised CS high; snap_seq +1 only.
REQ-029 Start address 0xFE, 3 data bytes -> 0x00 (0xFE), 0x00 (0xFF), 0x46 (wrapped to 0x00).
REQ-030 CS raised after 4 SCLK bits of the address byte, then a new transaction at 0x01 -> returns 0x02; the aborted byte has no effect.
REQ-031 Reset asserted mid-transaction with CS held low -> spi_miso=0, busy=0, snap_valid=0; no response until CS toggles high then low.
